// File: rtl/ram_sdp_rr_arbiter.sv
// -----------------------------------------------------------------------------
// ram_sdp_rr_arbiter
//
// Shares one simple dual-port synchronous RAM (read-first, one-cycle read
// latency) among NUM_REQ clients. The write port and the read port each have
// their own round-robin arbiter, so every cycle can carry at most one write
// and one read. All RAM-side controls are registered. Read data returns to
// the issuing client exactly two cycles after its grant.
//
// Ports
//   clk_i            clock, all logic on posedge
//   rst_i            synchronous active-high reset
//   wr_req_i         per-client write request, held with addr/data until granted
//   wr_addr_i        client i write address at [i*AW +: AW]
//   wr_data_i        client i write data at [i*DW +: DW]
//   wr_gnt_o         combinational one-hot (or zero) write grant
//   rd_req_i         per-client read request, held with addr until granted
//   rd_addr_i        client i read address at [i*AW +: AW]
//   rd_gnt_o         combinational one-hot (or zero) read grant
//   rd_valid_o       one-hot single-cycle pulse naming the owner of rd_data_o
//   rd_data_o        read data, meaningful only while |rd_valid_o
//   ram_we_o         registered RAM write enable
//   ram_write_addr_o registered RAM write address
//   ram_din_o        registered RAM write data
//   ram_re_o         registered RAM read enable
//   ram_read_addr_o  registered RAM read address
//   ram_dout_i       RAM read data, valid the cycle after ram_re_o
// -----------------------------------------------------------------------------
module ram_sdp_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 10,
  parameter int DW      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    wr_req_i,
  input  logic [NUM_REQ*AW-1:0] wr_addr_i,
  input  logic [NUM_REQ*DW-1:0] wr_data_i,
  output logic [NUM_REQ-1:0]    wr_gnt_o,
  input  logic [NUM_REQ-1:0]    rd_req_i,
  input  logic [NUM_REQ*AW-1:0] rd_addr_i,
  output logic [NUM_REQ-1:0]    rd_gnt_o,
  output logic [NUM_REQ-1:0]    rd_valid_o,
  output logic [DW-1:0]         rd_data_o,
  output logic                  ram_we_o,
  output logic [AW-1:0]         ram_write_addr_o,
  output logic [DW-1:0]         ram_din_o,
  output logic                  ram_re_o,
  output logic [AW-1:0]         ram_read_addr_o,
  input  logic [DW-1:0]         ram_dout_i
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Round-robin pick: search begins one past the last winner and wraps, so a
  // pointer of NUM_REQ-1 gives client 0 top priority.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [PW-1:0]      last);
    logic [NUM_REQ-1:0] gnt;
    logic               found;
    int                 idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

  logic [NUM_REQ-1:0] wr_gnt, rd_gnt;
  logic [PW-1:0]      wr_last_q, wr_last_d, rd_last_q, rd_last_d;
  logic               ram_we_q, ram_we_d, ram_re_q, ram_re_d;
  logic [AW-1:0]      ram_waddr_q, ram_waddr_d, ram_raddr_q, ram_raddr_d;
  logic [DW-1:0]      ram_din_q, ram_din_d;
  // tag1 tracks the read the RAM is performing now; tag2 the read whose data
  // the RAM is presenting now.
  logic [NUM_REQ-1:0] tag1_q, tag1_d, tag2_q, tag2_d;

  // NOTE: every signal assigned here gets a default first so that no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_gnt = '0;
    rd_gnt = '0;
    if (!rst_i) begin
      wr_gnt = rr_pick(wr_req_i, wr_last_q);
      rd_gnt = rr_pick(rd_req_i, rd_last_q);
    end

    wr_last_d   = wr_last_q;
    ram_we_d    = 1'b0;
    ram_waddr_d = ram_waddr_q;
    ram_din_d   = ram_din_q;
    rd_last_d   = rd_last_q;
    ram_re_d    = 1'b0;
    ram_raddr_d = ram_raddr_q;
    tag1_d      = rd_gnt;
    tag2_d      = tag1_q;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr_gnt[i]) begin
        wr_last_d   = PW'(i);
        ram_we_d    = 1'b1;
        ram_waddr_d = wr_addr_i[i*AW +: AW];
        ram_din_d   = wr_data_i[i*DW +: DW];
      end
      if (rd_gnt[i]) begin
        rd_last_d   = PW'(i);
        ram_re_d    = 1'b1;
        ram_raddr_d = rd_addr_i[i*AW +: AW];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_last_q   <= PW'(NUM_REQ - 1);
      rd_last_q   <= PW'(NUM_REQ - 1);
      ram_we_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_din_q   <= '0;
      ram_re_q    <= 1'b0;
      ram_raddr_q <= '0;
      tag1_q      <= '0;
      tag2_q      <= '0;
    end else begin
      wr_last_q   <= wr_last_d;
      rd_last_q   <= rd_last_d;
      ram_we_q    <= ram_we_d;
      ram_waddr_q <= ram_waddr_d;
      ram_din_q   <= ram_din_d;
      ram_re_q    <= ram_re_d;
      ram_raddr_q <= ram_raddr_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
    end
  end

  assign wr_gnt_o         = wr_gnt;
  assign rd_gnt_o         = rd_gnt;
  assign rd_valid_o       = tag2_q;
  assign rd_data_o        = ram_dout_i;
  assign ram_we_o         = ram_we_q;
  assign ram_write_addr_o = ram_waddr_q;
  assign ram_din_o        = ram_din_q;
  assign ram_re_o         = ram_re_q;
  assign ram_read_addr_o  = ram_raddr_q;

endmodule

// File: tb/tb_ram_sdp_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_sdp_rr_arbiter
//
// Bench for ram_sdp_rr_arbiter. A behavioural RAM macro sits on the RAM-side
// ports. A reference model (last-winner integers, a golden memory array
// updated at grant time) predicts grants and pushes the expected read
// response into a queue; a separate monitor compares rd_valid/rd_data every
// cycle against the queue head.
// -----------------------------------------------------------------------------
module tb_ram_sdp_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N-1:0]      wr_req, wr_gnt, rd_req, rd_gnt, rd_valid;
  logic [N*AW-1:0]   wr_addr, rd_addr;
  logic [N*DW-1:0]   wr_data;
  logic [DW-1:0]     rd_data, ram_din, ram_dout;
  logic [AW-1:0]     ram_waddr, ram_raddr;
  logic              ram_we, ram_re;

  ram_sdp_rr_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_gnt_o(wr_gnt),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data),
    .ram_we_o(ram_we), .ram_write_addr_o(ram_waddr), .ram_din_o(ram_din),
    .ram_re_o(ram_re), .ram_read_addr_o(ram_raddr), .ram_dout_i(ram_dout)
  );

  // Client state: pending flag plus held address/data per client.
  logic          wp[N], rp[N];
  logic [AW-1:0] wa[N], ra[N];
  logic [DW-1:0] wd[N];

  always_comb begin
    wr_req  = '0;
    rd_req  = '0;
    wr_addr = '0;
    rd_addr = '0;
    wr_data = '0;
    for (int i = 0; i < N; i++) begin
      wr_req[i]            = wp[i];
      rd_req[i]            = rp[i];
      wr_addr[i*AW +: AW]  = wa[i];
      rd_addr[i*AW +: AW]  = ra[i];
      wr_data[i*DW +: DW]  = wd[i];
    end
  end

  // RAM macro: read-first, registered read data.
  logic [DW-1:0] mem[1024];
  always @(posedge clk) begin
    if (ram_re) ram_dout <= mem[ram_raddr];
    if (ram_we) mem[ram_waddr] <= ram_din;
  end

  // Reference model state.
  logic [DW-1:0] gold[1024];
  int            wlast, rlast;
  bit            sticky;
  logic [N-1:0]  s_wgnt, s_rgnt;

  typedef struct {
    int           due;
    logic [N-1:0] oh;
    logic [DW-1:0] data;
  } exp_t;
  exp_t q[$];

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int passed, total;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // First requesting client searching from one past the last winner.
  function automatic int pick(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++)
      if (req[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // One clock cycle: predict and check grants mid-cycle, update the model,
  // then after the edge retire the granted requests.
  task automatic cycle();
    logic [N-1:0] wreq, rreq, ew, er;
    int w, r;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      wreq[i] = wp[i];
      rreq[i] = rp[i];
    end
    ew = '0; er = '0; w = -1; r = -1;
    if (!rst) begin
      w = pick(wreq, wlast);
      r = pick(rreq, rlast);
      if (w >= 0) ew[w] = 1'b1;
      if (r >= 0) er[r] = 1'b1;
    end
    s_wgnt = wr_gnt;
    s_rgnt = rd_gnt;
    check("wr_gnt", wr_gnt, ew);
    check("rd_gnt", rd_gnt, er);
    // Read is resolved before the write: same-cycle collisions see old data.
    if (r >= 0) begin
      q.push_back('{due: cyc + 2, oh: er, data: gold[ra[r]]});
      rlast = r;
    end
    if (w >= 0) begin
      gold[wa[w]] = wd[w];
      wlast = w;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      wlast = N - 1;
      rlast = N - 1;
      q.delete();
    end else if (!sticky) begin
      if (w >= 0) wp[w] = 1'b0;
      if (r >= 0) rp[r] = 1'b0;
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      wp[i] = 1'b0;
      rp[i] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int a;
    a = $urandom_range(0, 8);
    return (a == 8) ? AW'(1023) : AW'(a);
  endfunction

  // Monitor: the read response due this cycle (if any) must appear now.
  always @(negedge clk) begin
    logic [N-1:0] exp_oh;
    if (cyc >= 1) begin
      exp_oh = (q.size() > 0 && q[0].due == cyc) ? q[0].oh : '0;
      check("rd_valid", rd_valid, exp_oh);
      if (exp_oh != '0) begin
        check("rd_data", rd_data, q[0].data);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    passed = 0; total = 0; cyc = 0;
    sticky = 1'b0;
    wlast = N - 1; rlast = N - 1;
    ram_dout = '0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]  = '0;
      gold[i] = '0;
    end
    for (int i = 0; i < N; i++) begin
      wp[i] = 1'b1; rp[i] = 1'b1;
      wa[i] = AW'(i); ra[i] = AW'(i);
      wd[i] = DW'(32'h100 + i);
    end
    rst = 1'b1;

    // Reset with every client requesting.
    for (int k = 0; k < 2; k++) begin
      cycle();
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_re", ram_re, 0);
      check("rst_rd_valid", rd_valid, 0);
    end
    rst = 1'b0;

    // Fairness on both ports with all requests held.
    sticky = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("fair_wr", s_wgnt, 64'(1) << (k % N));
      check("fair_rd", s_rgnt, 64'(1) << (k % N));
    end
    sticky = 1'b0;
    clear_reqs();
    idle(3);

    // Write 1023 by client 2, read it back by client 1 one cycle later.
    wp[2] = 1'b1; wa[2] = 10'd1023; wd[2] = 32'hDEADBEEF;
    cycle();
    rp[1] = 1'b1; ra[1] = 10'd1023;
    cycle();
    cycle();
    check("wb_valid", rd_valid, 4'b0010);
    check("wb_data", rd_data, 32'hDEADBEEF);
    idle(2);

    // Read-first collision on address 5.
    wp[1] = 1'b1; wa[1] = 10'd5; wd[1] = 32'h1;
    cycle();
    wp[0] = 1'b1; wa[0] = 10'd5; wd[0] = 32'h2;
    rp[3] = 1'b1; ra[3] = 10'd5;
    cycle();
    rp[1] = 1'b1; ra[1] = 10'd5;
    cycle();
    check("coll_old_valid", rd_valid, 4'b1000);
    check("coll_old_data", rd_data, 32'h1);
    cycle();
    check("coll_new_valid", rd_valid, 4'b0010);
    check("coll_new_data", rd_data, 32'h2);
    idle(2);

    // Back-to-back reads by clients 0..3 at addresses 0..3.
    for (int k = 0; k < N; k++) begin
      rp[k] = 1'b1; ra[k] = AW'(k);
      cycle();
    end
    idle(3);

    // Reset while a read is in flight.
    wp[0] = 1'b1; wa[0] = 10'd7; wd[0] = 32'hCAFE0007;
    cycle();
    rp[2] = 1'b1; ra[2] = 10'd7;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_flight_no_valid", rd_valid, 0);
    idle(2);
    rp[3] = 1'b1; ra[3] = 10'd7;
    cycle();
    cycle();
    check("post_rst_valid", rd_valid, 4'b1000);
    check("post_rst_data", rd_data, 32'hCAFE0007);
    idle(2);

    // Randomized traffic over a small address set to provoke hazards.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!wp[i] && $urandom_range(0, 2) != 0) begin
          wp[i] = 1'b1; wa[i] = rand_addr(); wd[i] = $urandom();
        end
        if (!rp[i] && $urandom_range(0, 2) != 0) begin
          rp[i] = 1'b1; ra[i] = rand_addr();
        end
      end
      cycle();
    end
    clear_reqs();
    idle(4);
    check("queue_drained", 64'(q.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
